// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// load/store (MEM). The arbiter grants one side at a time and forwards that
// side's access through registered memory-side outputs. It returns one-cycle
// done pulses and exposes level stalls that freeze the pipeline while an
// access is outstanding. The data side and the fetch side alternate priority
// so that back-to-back loads cannot starve fetch. A watchdog aborts an access
// that never sees mem_ready and raises a sticky bus_err.

module mem_port_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    // data side (EX/MEM)
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_byte,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    // fetch side (IF)
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_stall,
    // memory side
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} stateType;

    // Last count value that may still see mem_ready; one more miss aborts.
    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    stateType    state, stateNext;
    logic [15:0] waitCnt, waitCntNext;
    logic        lastData, lastDataNext;
    logic        byteLat, byteLatNext;
    logic [1:0]  offLat, offLatNext;
    logic        weLat, weLatNext;

    logic        memReqNext, memWeNext, dDoneNext, iDoneNext, busErrNext;
    logic [31:0] memAddrNext, memWdataNext, dRdataNext, iRdataNext;

    logic        dElig, iElig, timeout;
    logic        grantData, grantFetch, goIdle;
    logic [7:0]  loadByte;
    logic [31:0] loadData;

    // A side's request is ignored during its own done cycle: the pipeline
    // advances at the end of that cycle, so the level still shows the old access.
    assign dElig   = d_req & ~d_done;
    assign iElig   = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;
    assign i_stall = i_req & ~i_done;

    // mem_ready landing on the final allowed edge still counts as success.
    assign timeout  = (waitCnt == WAIT_LAST) & ~mem_ready;

    // Little-endian byte lane picked by the latched low address bits.
    assign loadByte = mem_rdata[{offLat, 3'b000} +: 8];
    assign loadData = byteLat ? {{24{loadByte[7]}}, loadByte} : mem_rdata;

    // Next-state, arbitration and memory-side output decode.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        stateNext    = state;
        waitCntNext  = waitCnt;
        lastDataNext = lastData;
        byteLatNext  = byteLat;
        offLatNext   = offLat;
        weLatNext    = weLat;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        dDoneNext    = 1'b0;
        dRdataNext   = '0;
        iDoneNext    = 1'b0;
        iRdataNext   = '0;
        busErrNext   = bus_err;
        grantData    = 1'b0;
        grantFetch   = 1'b0;
        goIdle       = 1'b0;

        case (state)
            IDLE: begin
                if (dElig && (!iElig || !lastData)) grantData = 1'b1;
                else if (iElig)                     grantFetch = 1'b1;
            end
            D_BUSY: begin
                if (mem_ready || timeout) begin
                    dDoneNext    = 1'b1;
                    dRdataNext   = (mem_ready && !weLat) ? loadData : '0;
                    busErrNext   = bus_err | ~mem_ready;
                    lastDataNext = 1'b1;
                    if (iElig) grantFetch = 1'b1;
                    else       goIdle     = 1'b1;
                end else begin
                    waitCntNext = waitCnt + 16'd1;
                end
            end
            I_BUSY: begin
                if (mem_ready || timeout) begin
                    iDoneNext    = 1'b1;
                    iRdataNext   = mem_ready ? mem_rdata : '0;
                    busErrNext   = bus_err | ~mem_ready;
                    lastDataNext = 1'b0;
                    if (dElig) grantData = 1'b1;
                    else       goIdle    = 1'b1;
                end else begin
                    waitCntNext = waitCnt + 16'd1;
                end
            end
            default: goIdle = 1'b1;
        endcase

        if (grantData) begin
            stateNext    = D_BUSY;
            waitCntNext  = '0;
            memReqNext   = 1'b1;
            memWeNext    = d_we;
            memAddrNext  = {d_addr[31:2], 2'b00};
            memWdataNext = d_wdata;
            byteLatNext  = d_byte;
            offLatNext   = d_addr[1:0];
            weLatNext    = d_we;
        end else if (grantFetch) begin
            stateNext   = I_BUSY;
            waitCntNext = '0;
            memReqNext  = 1'b1;
            memWeNext   = 1'b0;
            memAddrNext = {i_addr[31:2], 2'b00};
        end else if (goIdle) begin
            stateNext  = IDLE;
            memReqNext = 1'b0;
            memWeNext  = 1'b0;
        end
    end

    // State and registered outputs; reset drops an in-flight access silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            lastData  <= 1'b0;
            byteLat   <= 1'b0;
            offLat    <= '0;
            weLat     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            state     <= stateNext;
            waitCnt   <= waitCntNext;
            lastData  <= lastDataNext;
            byteLat   <= byteLatNext;
            offLat    <= offLatNext;
            weLat     <= weLatNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            d_done    <= dDoneNext;
            d_rdata   <= dRdataNext;
            i_done    <= iDoneNext;
            i_rdata   <= iRdataNext;
            bus_err   <= busErrNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed stimulus with a scoreboard. Each stimulus task pushes the memory
// request it expects to appear and the done response it expects back. A memory
// model pops the request queue when an access starts, and a monitor pops the
// response queue on every done pulse.

module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_req, d_we, d_byte, d_done, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        i_req, i_done, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        mem_req, mem_we, mem_ready, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        bit          chkWdata;
        logic [31:0] rdata;
        int          lat;
    } memExpT;

    typedef struct {
        bit          isData;
        logic [31:0] rdata;
    } respT;

    memExpT memQ[$];
    respT   respQ[$];
    int     passCnt = 0;
    int     totalCnt = 0;

    // memory model state
    bit     mActive = 1'b0;
    bit     mReadyDriven = 1'b0;
    int     mWaitLeft = 0;
    memExpT mCur;

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte(d_byte), .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .i_stall(i_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory model: starts an access when mem_req appears, answers after lat cycles.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mReadyDriven || !mem_req) begin
                mem_ready    = 1'b0;
                mem_rdata    = '0;
                mActive      = 1'b0;
                mReadyDriven = 1'b0;
            end
            if (mem_req && !mActive) begin
                check("mem_req_expected", 32'(memQ.size() != 0), 32'd1);
                if (memQ.size() != 0) begin
                    mCur = memQ.pop_front();
                    check("mem_addr", mem_addr, mCur.addr);
                    check("mem_we", 32'(mem_we), 32'(mCur.we));
                    if (mCur.chkWdata) check("mem_wdata", mem_wdata, mCur.wdata);
                end else begin
                    mCur = '{default: 0};
                end
                mActive   = 1'b1;
                mWaitLeft = mCur.lat;
            end
            if (mActive) begin
                if (mWaitLeft == 0) begin
                    mem_ready    = 1'b1;
                    mem_rdata    = mCur.rdata;
                    mReadyDriven = 1'b1;
                end else begin
                    mWaitLeft--;
                end
            end
        end
    end

    // Monitor: every done pulse must match the oldest expected response.
    initial begin
        respT r;
        forever begin
            @(negedge clk);
            if (d_done || i_done) begin
                check("done_exclusive", 32'(d_done & i_done), 32'd0);
                check("resp_expected", 32'(respQ.size() != 0), 32'd1);
                if (respQ.size() != 0) begin
                    r = respQ.pop_front();
                    check("resp_side", 32'(d_done), 32'(r.isData));
                    check("resp_rdata", d_done ? d_rdata : i_rdata, r.rdata);
                end
            end
        end
    end

    task automatic runUntilDone(input bit isData, input int maxCyc, output int cyc, output int reqCyc);
        cyc = -1;
        reqCyc = 0;
        for (int c = 1; c <= maxCyc; c++) begin
            @(negedge clk);
            if (isData ? d_done : i_done) begin
                cyc = c;
                break;
            end
            if (mem_req) reqCyc++;
        end
    endtask

    task automatic dataAccess(input string name, input logic we, input logic isByte,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] memData, input logic [31:0] expData,
                              input int lat, input int expCyc);
        memExpT m;
        respT   r;
        int     cyc, reqCyc;
        m.addr = {addr[31:2], 2'b00}; m.we = we; m.wdata = wdata; m.chkWdata = 1'b1;
        m.rdata = memData; m.lat = lat;
        memQ.push_back(m);
        r.isData = 1'b1; r.rdata = expData;
        respQ.push_back(r);
        d_req = 1'b1; d_we = we; d_byte = isByte; d_addr = addr; d_wdata = wdata;
        #1 check({name, "_stall_on"}, 32'(d_stall), 32'd1);
        runUntilDone(1'b1, 40, cyc, reqCyc);
        check({name, "_cycles"}, 32'(cyc), 32'(expCyc));
        check({name, "_req_cycles"}, 32'(reqCyc), 32'(expCyc - 1));
        check({name, "_stall_off"}, 32'(d_stall), 32'd0);
        check({name, "_mem_req_idle"}, 32'(mem_req), 32'd0);
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        @(negedge clk);
    endtask

    task automatic fetchAccess(input string name, input logic [31:0] addr,
                               input logic [31:0] memData, input int lat, input int expCyc);
        memExpT m;
        respT   r;
        int     cyc, reqCyc;
        m.addr = {addr[31:2], 2'b00}; m.we = 1'b0; m.wdata = '0; m.chkWdata = 1'b0;
        m.rdata = memData; m.lat = lat;
        memQ.push_back(m);
        r.isData = 1'b0; r.rdata = memData;
        respQ.push_back(r);
        i_req = 1'b1; i_addr = addr;
        #1 check({name, "_stall_on"}, 32'(i_stall), 32'd1);
        runUntilDone(1'b0, 40, cyc, reqCyc);
        check({name, "_cycles"}, 32'(cyc), 32'(expCyc));
        check({name, "_req_cycles"}, 32'(reqCyc), 32'(expCyc - 1));
        check({name, "_stall_off"}, 32'(i_stall), 32'd0);
        check({name, "_mem_req_idle"}, 32'(mem_req), 32'd0);
        i_req = 1'b0;
        @(negedge clk);
    endtask

    // Both sides request together from IDLE; the first grant completes in 2
    // cycles and the second follows with no idle bubble on mem_req.
    task automatic contend(input string name, input bit dataFirst,
                           input logic [31:0] dAddr, input logic [31:0] iAddr,
                           input logic [31:0] dData, input logic [31:0] iData);
        memExpT md, mi;
        respT   rd, ri;
        int     dCyc, iCyc;
        bit     gap;
        md.addr = dAddr; md.we = 1'b0; md.wdata = '0; md.chkWdata = 1'b1; md.rdata = dData; md.lat = 0;
        mi.addr = iAddr; mi.we = 1'b0; mi.wdata = '0; mi.chkWdata = 1'b0; mi.rdata = iData; mi.lat = 0;
        rd.isData = 1'b1; rd.rdata = dData;
        ri.isData = 1'b0; ri.rdata = iData;
        if (dataFirst) begin
            memQ.push_back(md); memQ.push_back(mi);
            respQ.push_back(rd); respQ.push_back(ri);
        end else begin
            memQ.push_back(mi); memQ.push_back(md);
            respQ.push_back(ri); respQ.push_back(rd);
        end
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = dAddr; d_wdata = '0;
        i_req = 1'b1; i_addr = iAddr;
        dCyc = -1; iCyc = -1; gap = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (d_done && dCyc < 0) begin dCyc = c; d_req = 1'b0; end
            if (i_done && iCyc < 0) begin iCyc = c; i_req = 1'b0; end
            if ((dCyc < 0 || iCyc < 0) && !mem_req) gap = 1'b1;
            if (dCyc >= 0 && iCyc >= 0) break;
        end
        check({name, "_d_cycle"}, 32'(dCyc), dataFirst ? 32'd2 : 32'd3);
        check({name, "_i_cycle"}, 32'(iCyc), dataFirst ? 32'd3 : 32'd2);
        check({name, "_no_bubble"}, 32'(gap), 32'd0);
        d_req = 1'b0; i_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        memExpT m;
        respT   r;
        int     cyc, reqCyc;

        reset = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {27'b0, mem_req, mem_we, d_done, i_done, bus_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        fetchAccess("fetch40", 32'h0000_0040, 32'h1234_5678, 1, 3);
        dataAccess("store", 1'b1, 1'b0, 32'h0000_1006, 32'hDEAD_BEEF, 32'hAAAA_5555, 32'h0, 0, 2);
        dataAccess("lb3", 1'b0, 1'b1, 32'h0000_1003, 32'h1111_1111, 32'h80FF_0102, 32'hFFFF_FF80, 0, 2);
        dataAccess("lb1", 1'b0, 1'b1, 32'h0000_1001, 32'h2222_2222, 32'h80FF_0102, 32'h0000_0001, 0, 2);
        dataAccess("lb2", 1'b0, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_0102, 32'hFFFF_FFFF, 0, 2);
        dataAccess("lw", 1'b0, 1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 4);

        // Fetch last so last_data=0: data wins, then fetch follows back-to-back.
        fetchAccess("fetch44", 32'h0000_0044, 32'h0000_0013, 0, 2);
        contend("cont_d_first", 1'b1, 32'h0000_5000, 32'h0000_0048, 32'h1122_3344, 32'h2402_0001);

        // A load sets last_data=1; a following data request yields to fetch.
        dataAccess("lw2", 1'b0, 1'b0, 32'h0000_5004, 32'h0, 32'h5566_7788, 32'h5566_7788, 0, 2);
        contend("cont_i_first", 1'b0, 32'h0000_5008, 32'h0000_004C, 32'h99AA_BBCC, 32'h0800_0010);

        // Ready on the last allowed edge is a success, not a timeout.
        dataAccess("wd_edge", 1'b0, 1'b0, 32'h0000_6000, 32'h0, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 3, 5);
        check("wd_edge_no_err", 32'(bus_err), 32'd0);

        // Memory never answers: abort after 4 busy cycles.
        dataAccess("wd_abort", 1'b0, 1'b0, 32'h0000_7000, 32'h0, 32'h7777_7777, 32'h0, 100, 5);
        check("wd_abort_err", 32'(bus_err), 32'd1);
        fetchAccess("fetch80", 32'h0000_0080, 32'hABCD_0123, 0, 2);
        check("bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a data access.
        m.addr = 32'h0000_4000; m.we = 1'b0; m.wdata = '0; m.chkWdata = 1'b1; m.rdata = 32'h0; m.lat = 100;
        memQ.push_back(m);
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_4000; d_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mid_busy", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1 check("rst_mid_req_drop", 32'(mem_req), 32'd0);
        check("rst_mid_no_done", 32'(d_done), 32'd0);
        @(negedge clk);
        check("rst_mid_err_clr", 32'(bus_err), 32'd0);
        m.lat = 0; m.rdata = 32'h55AA_55AA;
        memQ.push_back(m);
        r.isData = 1'b1; r.rdata = 32'h55AA_55AA;
        respQ.push_back(r);
        reset = 1'b0;
        runUntilDone(1'b1, 20, cyc, reqCyc);
        check("rst_regrant_cycles", 32'(cyc), 32'd2);
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_resp_drained", 32'(respQ.size()), 32'd0);
        check("sb_mem_drained", 32'(memQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
